// File: rtl/frame_writer_pkg.sv
// Shared types and display constants for the frame writer and its swap handshake.
package frame_writer_pkg;

  localparam int unsigned DISPLAY_WIDTH  = 320;
  localparam int unsigned DISPLAY_HEIGHT = 240;
  localparam int unsigned ADDR_BITS      = 17;
  localparam int unsigned PIXEL_WIDTH    = 4;

  typedef enum logic [1:0] {
    WRITE     = 2'd0,
    SWAP_REQ  = 2'd1,
    SWAP_WAIT = 2'd2
  } frame_writer_state_t;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int unsigned fw_cnt_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/frame_writer_swap_handshake.sv
// Frame-end buffer swap: pulses swap_buffers, waits for which_bram to toggle, re-pulses on timeout.
// Optional FRAME_WRITER_VSYNC_SWAP_EN: swap is only issued while vblank is high.
module frame_writer_swap_handshake
  import frame_writer_pkg::*;
#(
  parameter int unsigned SWAP_TIMEOUT = 2**20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_frame_done,
  input  logic        i_vblank,
  input  logic        i_which_bram,
  output logic        o_next_write_c,
  output logic        o_swap,
  output logic [15:0] o_frame_count
);

  localparam int unsigned TMR_W = fw_cnt_width(SWAP_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SWAP_TIMEOUT - 1);

  frame_writer_state_t r_state, w_state_nxt;
  logic              r_old, w_old_nxt;
  logic [TMR_W-1:0]  r_timer, w_timer_nxt;
  logic              r_swap, w_swap_nxt;
  logic [15:0]       r_frame_count, w_count_nxt;
  logic              w_issue;

`ifdef FRAME_WRITER_VSYNC_SWAP_EN
  assign w_issue = i_vblank;
`else
  logic w_vblank_unused;
  assign w_vblank_unused = i_vblank;
  assign w_issue = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= WRITE;
      r_old         <= 1'b0;
      r_timer       <= '0;
      r_swap        <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_old         <= w_old_nxt;
      r_timer       <= w_timer_nxt;
      r_swap        <= w_swap_nxt;
      r_frame_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_old_nxt   = r_old;
    w_timer_nxt = r_timer;
    w_swap_nxt  = 1'b0;
    w_count_nxt = r_frame_count;
    case (r_state)
      WRITE: begin
        if (i_frame_done) w_state_nxt = SWAP_REQ;
      end
      SWAP_REQ: begin
        if (w_issue) begin
          w_old_nxt   = i_which_bram;
          w_swap_nxt  = 1'b1;
          w_timer_nxt = '0;
          w_state_nxt = SWAP_WAIT;
        end
      end
      SWAP_WAIT: begin
        // A toggle wins over a coincident timeout.
        if (i_which_bram != r_old) begin
          w_count_nxt = r_frame_count + 16'd1;
          w_state_nxt = WRITE;
        end else if (r_timer == TMR_LAST) begin
          w_state_nxt = SWAP_REQ;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      default: w_state_nxt = WRITE;
    endcase
  end

  assign o_next_write_c = (w_state_nxt == WRITE);
  assign o_swap         = r_swap;
  assign o_frame_count  = r_frame_count;

endmodule

// File: rtl/frame_writer.sv
// Writes a raster-ordered pixel stream into the back buffer and swaps buffers at frame end.
// Optional FRAME_WRITER_VSYNC_SWAP_EN: swap only during vertical blanking.
module frame_writer
  import frame_writer_pkg::*;
#(
  parameter int unsigned WIDTH        = PIXEL_WIDTH,
  parameter int unsigned DEPTH        = DISPLAY_WIDTH * DISPLAY_HEIGHT,
  parameter int unsigned ADDR_LEN     = ADDR_BITS,
  parameter int unsigned SWAP_TIMEOUT = 2**20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pixel_valid,
  input  logic [WIDTH-1:0]    pixel_data,
  input  logic                pixel_sof,
  output logic                pixel_ready,
  input  logic                vblank_in,
  input  logic                which_bram_in,
  output logic                write_enable,
  output logic [ADDR_LEN-1:0] write_addr,
  output logic [WIDTH-1:0]    write_data,
  output logic                swap_buffers,
  output logic [15:0]         frame_count,
  output logic                busy
);

  localparam logic [ADDR_LEN-1:0] LAST_ADDR = ADDR_LEN'(DEPTH - 1);

  logic [ADDR_LEN-1:0] r_addr;
  logic                r_ready;
  logic                r_busy;
  logic                r_we;
  logic [ADDR_LEN-1:0] r_waddr;
  logic [WIDTH-1:0]    r_wdata;

  logic                w_accept;
  logic [ADDR_LEN-1:0] w_beat_addr;
  logic                w_last;
  logic                w_frame_done;
  logic [ADDR_LEN-1:0] w_addr_nxt;
  logic                w_next_write;

  // sof restarts the frame at addr 0; the counter then continues from 1.
  always_comb begin
    w_accept     = pixel_valid && r_ready;
    w_beat_addr  = pixel_sof ? '0 : r_addr;
    w_last       = (w_beat_addr == LAST_ADDR);
    w_frame_done = w_accept && w_last;
    w_addr_nxt   = r_addr;
    if (w_accept) begin
      w_addr_nxt = w_last ? '0 : w_beat_addr + ADDR_LEN'(1);
    end
  end

  frame_writer_swap_handshake #(
    .SWAP_TIMEOUT (SWAP_TIMEOUT)
  ) u_swap (
    .clk            (clk),
    .rst            (rst),
    .i_frame_done   (w_frame_done),
    .i_vblank       (vblank_in),
    .i_which_bram   (which_bram_in),
    .o_next_write_c (w_next_write),
    .o_swap         (swap_buffers),
    .o_frame_count  (frame_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_addr  <= w_addr_nxt;
      r_ready <= w_next_write;
      r_busy  <= !(w_next_write && (w_addr_nxt == '0));
      r_we    <= w_accept;
      if (w_accept) begin
        r_waddr <= w_beat_addr;
        r_wdata <= pixel_data;
      end
    end
  end

  assign pixel_ready  = r_ready;
  assign busy         = r_busy;
  assign write_enable = r_we;
  assign write_addr   = r_waddr;
  assign write_data   = r_wdata;

endmodule

// File: tb/tb_frame_writer.sv
// Directed self-checking bench for frame_writer (DEPTH=16, SWAP_TIMEOUT=8) with a bram_manager toggle model.
module tb_frame_writer;

  logic        clk;
  logic        rst;
  logic        pixel_valid;
  logic [3:0]  pixel_data;
  logic        pixel_sof;
  logic        pixel_ready;
  logic        vblank_in;
  logic        which_bram_in;
  logic        write_enable;
  logic [3:0]  write_addr;
  logic [3:0]  write_data;
  logic        swap_buffers;
  logic [15:0] frame_count;
  logic        busy;

  int   total;
  int   bad;
  int   cyc;
  int   pulses;
  int   toggle_at;
  int   pcyc [4];
  logic acc;

  frame_writer #(
    .WIDTH        (4),
    .DEPTH        (16),
    .ADDR_LEN     (4),
    .SWAP_TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pixel_valid   (pixel_valid),
    .pixel_data    (pixel_data),
    .pixel_sof     (pixel_sof),
    .pixel_ready   (pixel_ready),
    .vblank_in     (vblank_in),
    .which_bram_in (which_bram_in),
    .write_enable  (write_enable),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .swap_buffers  (swap_buffers),
    .frame_count   (frame_count),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // One cycle of stimulus; models bram_manager toggling which_bram on selected swap pulses.
  task automatic step(input logic v, input logic [3:0] d, input logic s);
    acc         = v && pixel_ready;
    pixel_valid = v;
    pixel_data  = d;
    pixel_sof   = s;
    tick();
    if (swap_buffers) begin
      chk("swap_vs_we", 32'(write_enable), 0);
      chk("swap_vs_ready", 32'(pixel_ready), 0);
      if (pulses < 4) pcyc[pulses] = cyc;
      pulses++;
      if (pulses % toggle_at == 0) which_bram_in = ~which_bram_in;
    end
  endtask

  task automatic chk_wr(input logic [3:0] a, input logic [3:0] d);
    chk("we", 32'(write_enable), 1);
    chk("waddr", 32'(write_addr), 32'(a));
    chk("wdata", 32'(write_data), 32'(d));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!(pixel_ready && !busy) && n < budget) begin
      step(1'b0, 4'h0, 1'b0);
      n++;
    end
    chk("drain_done", 32'(pixel_ready && !busy), 1);
  endtask

  initial begin
    int fc0;
    int nacc;
    int n;
    logic v;

    total = 0; bad = 0; cyc = 0; pulses = 0; toggle_at = 1;
    rst = 1'b1; pixel_valid = 1'b0; pixel_data = 4'h0; pixel_sof = 1'b0;
    which_bram_in = 1'b0;
`ifdef FRAME_WRITER_VSYNC_SWAP_EN
    vblank_in = 1'b1;
`else
    vblank_in = 1'b0;
`endif

    // Reset values
    tick();
    tick();
    chk("rst_we", 32'(write_enable), 0);
    chk("rst_waddr", 32'(write_addr), 0);
    chk("rst_wdata", 32'(write_data), 0);
    chk("rst_swap", 32'(swap_buffers), 0);
    chk("rst_fc", 32'(frame_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(pixel_ready), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(pixel_ready), 1);
    chk("post_rst_busy", 32'(busy), 0);

    // Full frame, valid held high
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 4'(k), 1'b0);
      chk_wr(4'(k), 4'(k));
      chk("f1_ready", 32'(pixel_ready), (k < 15) ? 1 : 0);
      chk("f1_swap_early", 32'(swap_buffers), 0);
    end
    chk("f1_busy", 32'(busy), 1);
    step(1'b1, 4'h0, 1'b0);
    chk("f1_no_accept", 32'(acc), 0);
    chk("f1_swap", 32'(swap_buffers), 1);
    chk("f1_we_off", 32'(write_enable), 0);
    step(1'b0, 4'h0, 1'b0);
    chk("f1_swap_one", 32'(swap_buffers), 0);
    chk("f1_fc", 32'(frame_count), 1);
    chk("f1_ready_back", 32'(pixel_ready), 1);
    chk("f1_busy_clr", 32'(busy), 0);
    chk("f1_pulses", 32'(pulses), 1);

    // Random valid gaps over three frames
    fc0 = int'(frame_count); pulses = 0; nacc = 0; n = 0;
    while (nacc < 48 && n < 2000) begin
      v = 1'($urandom_range(0, 1));
      step(v, 4'(nacc), 1'b0);
      if (acc) begin
        chk_wr(4'(nacc), 4'(nacc));
        nacc++;
      end else begin
        chk("gap_we", 32'(write_enable), 0);
      end
      n++;
    end
    chk("rand_beats", 32'(nacc), 48);
    drain(50);
    chk("rand_fc", 32'(frame_count), 32'(fc0 + 3));
    chk("rand_pulses", 32'(pulses), 3);

    // sof mid-frame: partial frame discarded
    fc0 = int'(frame_count); pulses = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 4'(i), 1'b0);
      chk_wr(4'(i), 4'(i));
    end
    step(1'b1, 4'hA, 1'b1);
    chk_wr(4'h0, 4'hA);
    chk("sof_ready", 32'(pixel_ready), 1);
    for (int j = 1; j < 16; j++) begin
      step(1'b1, 4'(j + 3), 1'b0);
      chk_wr(4'(j), 4'(j + 3));
      if (j == 14) chk("sof_no_swap", 32'(pixel_ready), 1);
    end
    chk("sof_end_ready", 32'(pixel_ready), 0);
    chk("sof_pulses0", 32'(pulses), 0);
    drain(20);
    chk("sof_fc", 32'(frame_count), 32'(fc0 + 1));
    chk("sof_pulses", 32'(pulses), 1);

    // Swap timeout: which_bram toggles only on the third pulse
    fc0 = int'(frame_count); pulses = 0; toggle_at = 3;
    for (int k = 0; k < 16; k++) step(1'b1, 4'(k), 1'b0);
    drain(60);
    chk("to_pulses", 32'(pulses), 3);
    chk("to_period1", 32'(pcyc[1] - pcyc[0]), 9);
    chk("to_period2", 32'(pcyc[2] - pcyc[1]), 9);
    chk("to_fc", 32'(frame_count), 32'(fc0 + 1));
    toggle_at = 1;

`ifdef FRAME_WRITER_VSYNC_SWAP_EN
    // Swap held off until vblank
    fc0 = int'(frame_count); pulses = 0; vblank_in = 1'b0;
    for (int k = 0; k < 16; k++) step(1'b1, 4'(k), 1'b0);
    for (int k = 0; k < 20; k++) step(1'b0, 4'h0, 1'b0);
    chk("vs_hold", 32'(pulses), 0);
    vblank_in = 1'b1;
    step(1'b0, 4'h0, 1'b0);
    chk("vs_pulse", 32'(swap_buffers), 1);
    drain(20);
    chk("vs_fc", 32'(frame_count), 32'(fc0 + 1));
`endif

    // Asynchronous reset mid-frame
    for (int k = 0; k < 9; k++) step(1'b1, 4'(k), 1'b0);
    chk("pre_rst_we", 32'(write_enable), 1);
    pixel_valid = 1'b1;
    pixel_data  = 4'h9;
    #1 rst = 1'b1;
    #1;
    chk("arst_we", 32'(write_enable), 0);
    chk("arst_waddr", 32'(write_addr), 0);
    chk("arst_wdata", 32'(write_data), 0);
    chk("arst_fc", 32'(frame_count), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ready", 32'(pixel_ready), 0);
    chk("arst_swap", 32'(swap_buffers), 0);
    @(negedge clk);
    rst = 1'b0;
    pixel_valid = 1'b0;
    tick();
    chk("arst_ready_back", 32'(pixel_ready), 1);
    step(1'b1, 4'h5, 1'b0);
    chk_wr(4'h0, 4'h5);
    chk("arst_fc_after", 32'(frame_count), 0);
    step(1'b0, 4'h0, 1'b0);
    chk("arst_idle_we", 32'(write_enable), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_writer.md
Name: frame_writer

Overview:
- Write-side counterpart to the VGA read path of the double-buffered pixel memory.
- Accepts a raster-ordered 4-bit pixel stream from the renderer over a valid/ready handshake.
- Issues sequential writes into bram_manager's back buffer through its write_enable/write_addr/write_data port.
- At frame end, pulses swap_buffers and stalls the stream until the buffers have actually exchanged.

Parameters:
- WIDTH, 4, pixel width in bits; matches bram_manager WIDTH.
- DEPTH, `DISPLAY_WIDTH*`DISPLAY_HEIGHT, pixels per frame.
- ADDR_LEN, `ADDR_BITS, address width; requires 2**ADDR_LEN >= DEPTH.
- SWAP_TIMEOUT, 2**20, cycles to wait for which_bram toggle before re-pulsing swap.

Ports:
- clk  input  1  system clock, same as bram_manager.
- rst  input  1  asynchronous, active-high reset.
- pixel_valid  input  1  upstream pixel available.
- pixel_data  input  WIDTH  pixel value.
- pixel_sof  input  1  qualifies the current beat as the first pixel of a frame.
- pixel_ready  output  1  this block can accept a beat this cycle.
- vblank_in  input  1  display vertical blanking; used only with the optional feature.
- which_bram_in  input  1  bram_manager which_bram_out.
- write_enable  output  1  to bram_manager.
- write_addr  output  ADDR_LEN  to bram_manager.
- write_data  output  WIDTH  to bram_manager.
- swap_buffers  output  1  single-cycle swap request to bram_manager.
- frame_count  output  16  completed (swapped) frames, wraps at 65535 -> 0.
- busy  output  1  high in any state other than WRITE with addr == 0.

Behaviour:
- Reset: asynchronous, active-high. Default values while in reset:
  - State = WRITE, addr counter = 0.
  - write_enable = 0, write_addr = 0, write_data = 0.
  - swap_buffers = 0, frame_count = 0, busy = 0.
  - pixel_ready = 1 after the first clock edge following deassertion.
- Handshake: a beat transfers when pixel_valid && pixel_ready at a rising edge. pixel_ready is 1 only in WRITE.
- Write port: registered.
  - A beat accepted at edge N gives write_enable = 1, write_addr = addr, write_data = pixel_data during cycle N+1.
  - write_enable = 0 in any cycle without an accepted beat on the previous edge.
- Address: starts at 0 and increments per accepted beat.
  - pixel_sof on an accepted beat forces that beat to addr 0, the partial frame is discarded (no swap), and the counter continues from 1.
  - pixel_sof on the beat at addr 0 is a no-op.
- State machine:
  - WRITE: accept beats. The beat written at addr DEPTH-1 resets addr to 0 and moves to SWAP_REQ on the same edge. No beat is accepted in the following cycle.
  - SWAP_REQ: latch old = which_bram_in. Assert swap_buffers for exactly one cycle (with VSYNC feature: only when vblank_in = 1, else hold in SWAP_REQ). Go to SWAP_WAIT.
  - SWAP_WAIT: when which_bram_in != old, increment frame_count and go to WRITE. If the timeout counter reaches SWAP_TIMEOUT-1, return to SWAP_REQ and re-pulse.
- The final write (cycle after the DEPTH-1 accept) always completes before swap_buffers asserts; swap_buffers is never high in the same cycle as write_enable.
- Reset mid-frame: partial frame abandoned, no swap issued, addr restarts at 0.
- pixel_valid during SWAP_REQ/SWAP_WAIT: held off (ready = 0), no data lost.
- DEPTH = 1 is legal: every beat triggers a swap.

Optional Feature:
- FRAME_WRITER_VSYNC_SWAP_EN defined: swap_buffers is issued only during a cycle with vblank_in = 1. This prevents mid-scan tearing.
- Undefined: vblank_in is ignored and the swap is issued on the first SWAP_REQ cycle. The port remains present either way.

Decomposition:
- Shared types header gets: a frame_writer_state_t enum (WRITE, SWAP_REQ, SWAP_WAIT) and a PIXEL_WIDTH = 4 constant.
- ADDR_BITS, DISPLAY_WIDTH and DISPLAY_HEIGHT already live there.
- One natural sub-module: swap_handshake, containing SWAP_REQ/SWAP_WAIT, the timeout counter, toggle detection and frame_count. frame_writer keeps address and write-port logic.

Test Plan:
- DEPTH=16, stream 16 beats of data = index[3:0] with valid held high -> writes to addr 0..15 in order, each one cycle after accept. One swap_buffers pulse follows the addr 15 write. Model toggles which_bram; frame_count = 1 and ready returns to 1.
- Random pixel_valid gaps (50%) over 3 frames -> no skipped or duplicated addresses, frame_count = 3, pixel_ready = 0 throughout every SWAP_REQ/SWAP_WAIT window.
- pixel_sof asserted on beat 7 of a frame -> that beat written to addr 0, no swap for the partial frame, next swap after 16 further beats.
- which_bram model never toggles, SWAP_TIMEOUT=8 -> swap_buffers re-pulses every ~9 cycles. Toggling on the third pulse gives frame_count = 1.
- FRAME_WRITER_VSYNC_SWAP_EN defined, vblank_in low for 20 cycles after frame end -> swap_buffers stays 0, then pulses in the first cycle vblank_in = 1.
- Assert rst during beat 9 -> all outputs zero immediately (asynchronously). After release, the next beat goes to addr 0 and frame_count = 0.
